// File: rtl/master_port_if.sv
// Serial bus between a master port and the arbiter/slave side.
// The master modport drives request, serial write data, mode and valid; the slave modport drives the rest.
interface master_port_if;
  logic mbreq;
  logic mbgrant;
  logic mwdata;
  logic mmode;
  logic mvalid;
  logic mrdata;
  logic svalid;
  logic sready;
  logic ssplit;

  modport master (
    output mbreq, mwdata, mmode, mvalid,
    input  mbgrant, mrdata, svalid, sready, ssplit
  );

  modport slave (
    input  mbreq, mwdata, mmode, mvalid,
    output mbgrant, mrdata, svalid, sready, ssplit
  );
endinterface

// File: rtl/master_port.sv
// Serial bus master: takes one parallel read/write request, shifts address/write data out LSB-first,
// and deserialises read data. Optional RWAIT/SPLIT timeout is enabled by defining MASTER_TIMEOUT_EN.
module master_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  derr,
  master_port_if.master         bus
);

  localparam int unsigned MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] AW_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_SPLIT, S_RDATA, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_sh;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_sh;
  logic [DATA_WIDTH-1:0] r_rbuf, w_rbuf_nxt, w_bit_mask;
  logic [DATA_WIDTH-1:0] r_drdata;
  logic                  r_dready;
  logic                  r_derr;
  logic                  w_accept, w_capture, w_timeout, w_tmo_hit;
  logic                  w_mbreq, w_mvalid, w_mwdata, w_mmode;

  assign w_addr_sh  = r_addr >> r_cnt;
  assign w_wdata_sh = r_wdata >> r_cnt;
  assign w_bit_mask = DATA_WIDTH'(1) << r_cnt;

`ifdef MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tcnt;

  // Cleared while the address goes out, so it measures the whole RWAIT+SPLIT wait; frozen elsewhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  r_tcnt <= '0;
    else if (r_state == S_ADDR)                 r_tcnt <= '0;
    else if (r_state inside {S_RWAIT, S_SPLIT}) r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_tmo_hit = (r_tcnt == TMO_LAST);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_mbreq     = 1'b0;
    w_mvalid    = 1'b0;
    w_mwdata    = 1'b0;
    w_mmode     = 1'b0;
    w_rbuf_nxt  = r_rbuf;

    unique case (r_state)
      S_IDLE: begin
        if (r_dready && dvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_mbreq = 1'b1;
        if (bus.mbgrant && bus.sready) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_mbreq  = 1'b1;
        w_mvalid = 1'b1;
        w_mmode  = r_mode;
        w_mwdata = w_addr_sh[0];
        if (r_cnt == AW_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_mode ? S_WDATA : S_RWAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WDATA: begin
        w_mbreq  = 1'b1;
        w_mvalid = 1'b1;
        w_mwdata = w_wdata_sh[0];
        if (r_cnt == DW_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RWAIT: begin
        w_mbreq = 1'b1;
        if (bus.svalid)      w_capture = 1'b1;
        else if (bus.ssplit) w_state_nxt = S_SPLIT;
        else if (w_tmo_hit)  w_timeout = 1'b1;
      end
      S_SPLIT: begin
        if (bus.svalid)     w_capture = 1'b1;
        else if (w_tmo_hit) w_timeout = 1'b1;
      end
      S_RDATA: begin
        w_mbreq = 1'b1;
        if (bus.svalid) w_capture = 1'b1;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Bit capture is shared by RWAIT/SPLIT (cnt is 0 there) and RDATA.
    if (w_capture) begin
      w_rbuf_nxt = (r_rbuf & ~w_bit_mask) | (bus.mrdata ? w_bit_mask : '0);
      if (r_cnt == DW_LAST) begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DONE;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = S_RDATA;
      end
    end
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rbuf   <= '0;
      r_drdata <= '0;
      r_dready <= 1'b0;
      r_derr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dready <= (w_state_nxt == S_IDLE);
      r_derr   <= w_timeout;
      r_rbuf   <= w_rbuf_nxt;
      if (w_accept) begin
        r_mode  <= dmode;
        r_addr  <= daddr;
        r_wdata <= dwdata;
        r_rbuf  <= '0;
      end
      if (w_capture && (r_cnt == DW_LAST)) r_drdata <= w_rbuf_nxt;
    end
  end

  // dready is registered so it reads 0 while reset is asserted.
  assign dready     = r_dready;
  assign drdata     = r_drdata;
  assign drvalid    = (r_state == S_DONE);
  assign derr       = r_derr;
  assign bus.mbreq  = w_mbreq;
  assign bus.mvalid = w_mvalid;
  assign bus.mwdata = w_mwdata;
  assign bus.mmode  = w_mmode;

endmodule
